spi_board_receiver: RTL and testbench

//  SPI slave that receives a ROWS x COLS game board, one WORD_W-bit cell per cs-high burst, in row-major order.

---
 rtl/spi_board_pkg.sv | 18 +
 rtl/spi_word_shifter.sv | 51 +++++
 rtl/spi_board_receiver.sv | 172 +++++++++++++++++
 tb/tb_spi_board_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_board_pkg.sv
// Shared types and width helpers for the SPI game-board receiver.
package spi_board_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, FULL} rx_state_e;

    localparam logic [7:0] FILLED_CHAR = 8'h23;

    // Address width for n entries; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold counts 0..n inclusive.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// Serial-to-parallel word assembler: bit counter plus shift register, one word per cs burst.
module spi_word_shifter
    import spi_board_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              cs_i,
    input  logic              sdi_i,
    input  logic              en_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o,
    output logic              short_drop_o
);

    localparam int CNT_W = ptr_w(WORD_W);

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic              last_bit;

    // The word includes the bit on sdi this edge, so completion needs no extra cycle.
    assign word_o       = MSB_FIRST ? {shreg_q, sdi_i} : {sdi_i, shreg_q};
    assign last_bit     = (bit_cnt_q == CNT_W'(WORD_W - 1));
    assign word_done_o  = cs_i && en_i && last_bit;
    assign short_drop_o = !cs_i && (bit_cnt_q != '0);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (flush_i || !cs_i) begin
            bit_cnt_d = '0;
        end else if (en_i) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
            shreg_d   = MSB_FIRST ? word_o[WORD_W-2:0] : word_o[WORD_W-1:1];
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/spi_board_receiver.sv
// SPI slave that fills a ROWS x COLS board row-major, one cell per cs burst,
// tracking filled-cell count, full rows, completion and framing errors.
module spi_board_receiver
    import spi_board_pkg::*;
#(
    parameter int              ROWS       = 32,
    parameter int              COLS       = 32,
    parameter int              WORD_W     = 8,
    parameter logic [WORD_W-1:0] MATCH_CHAR = WORD_W'(FILLED_CHAR),
    parameter bit              MSB_FIRST  = 1'b1,
    localparam int             ROW_W      = ptr_w(ROWS),
    localparam int             COL_W      = ptr_w(COLS),
    localparam int             MC_W       = count_w(ROWS * COLS)
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              cs_i,
    input  logic              sdi_i,
    input  logic              clear_i,
    input  logic [ROW_W-1:0]  rd_row_i,
    input  logic [COL_W-1:0]  rd_col_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              word_valid_o,
    output logic [ROW_W-1:0]  word_row_o,
    output logic [COL_W-1:0]  word_col_o,
    output logic [MC_W-1:0]   match_count_o,
    output logic [ROWS-1:0]   row_full_o,
    output logic              done_o,
    output logic              short_err_o,
    output logic              overrun_o
);

    rx_state_e         state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, wrow_q, wrow_d;
    logic [COL_W-1:0]  col_q, col_d, wcol_q, wcol_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [ROWS-1:0]   row_full_q, row_full_d;
    logic              acc_q, acc_d, acc_in;
    logic              done_q, done_d, short_q, short_d, ovr_q, ovr_d, wv_q, wv_d;
    logic              wr_en, is_match;
    logic [WORD_W-1:0] word;
    logic              word_done, short_drop;
    logic [WORD_W-1:0] board_q [ROWS][COLS];

    function automatic logic [MC_W-1:0] sat_inc(input logic [MC_W-1:0] c, input logic inc);
        if (inc && (c != MC_W'(ROWS * COLS))) return c + 1'b1;
        return c;
    endfunction

    spi_word_shifter #(
        .WORD_W   (WORD_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .sclk        (sclk),
        .reset       (reset),
        .cs_i        (cs_i),
        .sdi_i       (sdi_i),
        .en_i        (state_q != HOLD),
        .flush_i     (clear_i),
        .word_o      (word),
        .word_done_o (word_done),
        .short_drop_o(short_drop)
    );

    assign is_match = (word == MATCH_CHAR);
    assign acc_in   = (col_q == '0) ? 1'b1 : acc_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        wrow_d     = wrow_q;
        wcol_d     = wcol_q;
        mc_d       = mc_q;
        row_full_d = row_full_q;
        acc_d      = acc_q;
        done_d     = done_q;
        short_d    = short_q;
        ovr_d      = ovr_q;
        wv_d       = 1'b0;
        wr_en      = 1'b0;
        if (clear_i) begin
            state_d    = IDLE;
            row_d      = '0;
            col_d      = '0;
            mc_d       = '0;
            row_full_d = '0;
            done_d     = 1'b0;
            short_d    = 1'b0;
            ovr_d      = 1'b0;
        end else begin
            if (short_drop) short_d = 1'b1;
            case (state_q)
                IDLE:    if (cs_i) state_d = SHIFT;
                SHIFT:   if (!cs_i) state_d = IDLE;
                         else if (word_done) state_d = HOLD;
                HOLD:    if (!cs_i) state_d = IDLE;
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
            if (word_done && done_q) begin
                ovr_d = 1'b1;
            end else if (word_done) begin
                wr_en  = 1'b1;
                wv_d   = 1'b1;
                wrow_d = row_q;
                wcol_d = col_q;
                mc_d   = sat_inc(mc_q, is_match);
                acc_d  = acc_in & is_match;
                if (col_q == COL_W'(COLS - 1)) begin
                    row_full_d[row_q] = acc_in & is_match;
                    col_d = '0;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = FULL;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            wrow_q     <= '0;
            wcol_q     <= '0;
            mc_q       <= '0;
            row_full_q <= '0;
            acc_q      <= 1'b0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
            ovr_q      <= 1'b0;
            wv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wrow_q     <= wrow_d;
            wcol_q     <= wcol_d;
            mc_q       <= mc_d;
            row_full_q <= row_full_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
            short_q    <= short_d;
            ovr_q      <= ovr_d;
            wv_q       <= wv_d;
        end
    end

    // Board storage is deliberately not reset; only the frame bookkeeping is.
    always_ff @(posedge sclk) begin
        if (wr_en && !reset) board_q[row_q][col_q] <= word;
    end

    assign rd_data_o     = board_q[rd_row_i][rd_col_i];
    assign word_valid_o  = wv_q;
    assign word_row_o    = wrow_q;
    assign word_col_o    = wcol_q;
    assign match_count_o = mc_q;
    assign row_full_o    = row_full_q;
    assign done_o        = done_q;
    assign short_err_o   = short_q;
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_spi_board_receiver.sv
// Directed bench for a 4x4 board of 8-bit cells, MSB-first and LSB-first instances.
module tb_spi_board_receiver;

    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0, sdi = 1'b0, cs2 = 1'b0, sdi2 = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] rd_row = '0, rd_col = '0;

    logic [7:0] rd_data, rd_data2;
    logic       wv, wv2, done, done2, short_err, short_err2, overrun, overrun2;
    logic [1:0] wrow, wcol, wrow2, wcol2;
    logic [4:0] mc, mc2;
    logic [3:0] row_full, row_full2;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    logic [1:0] lrow = '0, lcol = '0;

    spi_board_receiver #(.ROWS(4), .COLS(4), .WORD_W(8), .MATCH_CHAR(8'h23), .MSB_FIRST(1'b1)) dut (
        .sclk(sclk), .reset(reset), .cs_i(cs), .sdi_i(sdi), .clear_i(clear),
        .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_data_o(rd_data),
        .word_valid_o(wv), .word_row_o(wrow), .word_col_o(wcol),
        .match_count_o(mc), .row_full_o(row_full), .done_o(done),
        .short_err_o(short_err), .overrun_o(overrun)
    );

    spi_board_receiver #(.ROWS(4), .COLS(4), .WORD_W(8), .MATCH_CHAR(8'h23), .MSB_FIRST(1'b0)) dut_lsb (
        .sclk(sclk), .reset(reset), .cs_i(cs2), .sdi_i(sdi2), .clear_i(clear),
        .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_data_o(rd_data2),
        .word_valid_o(wv2), .word_row_o(wrow2), .word_col_o(wcol2),
        .match_count_o(mc2), .row_full_o(row_full2), .done_o(done2),
        .short_err_o(short_err2), .overrun_o(overrun2)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (wv) begin
            vcnt <= vcnt + 1;
            lrow <= wrow;
            lcol <= wcol;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         row;
        int         col;
    } vec_t;

    vec_t tbl [32];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bits beyond the eighth are driven as ones so a HOLD leak would corrupt the cell.
    task automatic send(input logic [7:0] w, input int nbits, input bit lsb_dut);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            @(negedge sclk);
            if (i < 8) b = lsb_dut ? w[i] : w[7-i];
            else       b = 1'b1;
            if (lsb_dut) begin cs2 = 1'b1; sdi2 = b; end
            else         begin cs  = 1'b1; sdi  = b; end
        end
        @(negedge sclk);
        cs = 1'b0; sdi = 1'b0; cs2 = 1'b0; sdi2 = 1'b0;
        @(negedge sclk);
    endtask

    task automatic rd(input string name, input int r, input int c, input int exp);
        rd_row = 2'(r);
        rd_col = 2'(c);
        #1;
        chk(name, int'(rd_data), exp);
    endtask

    task automatic run_table(input int first, input int n);
        int v0;
        for (int k = first; k < first + n; k++) begin
            v0 = vcnt;
            send(tbl[k].data, 8, 1'b0);
            chk("word_valid_pulses", vcnt - v0, 1);
            chk("word_row", int'(lrow), tbl[k].row);
            chk("word_col", int'(lcol), tbl[k].col);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word_valid"}, int'(wv), 0);
        chk({tag, "_word_row"}, int'(wrow), 0);
        chk({tag, "_word_col"}, int'(wcol), 0);
        chk({tag, "_match_count"}, int'(mc), 0);
        chk({tag, "_row_full"}, int'(row_full), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_short_err"}, int'(short_err), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        int v0;
        for (int i = 0; i < 16; i++) begin
            tbl[i]      = '{8'(i), i / 4, i % 4};
            tbl[16 + i] = '{((i / 4) == 1) ? 8'h23 : 8'h2E, i / 4, i % 4};
        end

        repeat (2) @(negedge sclk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge sclk);

        // Frame of 0x00..0x0F
        run_table(0, 16);
        chk("t1_done", int'(done), 1);
        chk("t1_match_count", int'(mc), 0);
        rd("t1_rd_2_1", 2, 1, 8'h09);
        rd("t1_rd_3_3", 3, 3, 8'h0F);

        // Word after done
        v0 = vcnt;
        send(8'hAA, 8, 1'b0);
        chk("t4_overrun", int'(overrun), 1);
        chk("t4_no_valid", vcnt - v0, 0);
        rd("t4_rd_0_0", 0, 0, 8'h00);

        @(negedge sclk); clear = 1'b1;
        @(negedge sclk); clear = 1'b0;
        chk("clr_done", int'(done), 0);
        chk("clr_overrun", int'(overrun), 0);

        // Row 1 filled with '#'
        run_table(16, 16);
        chk("t2_row_full", int'(row_full), 4'b0010);
        chk("t2_match_count", int'(mc), 4);
        chk("t2_done", int'(done), 1);
        @(negedge sclk); clear = 1'b1;
        @(negedge sclk); clear = 1'b0;
        chk("t2c_row_full", int'(row_full), 0);
        chk("t2c_match_count", int'(mc), 0);
        chk("t2c_done", int'(done), 0);
        rd("t2c_rd_1_2", 1, 2, 8'h23);
        rd("t2c_rd_0_0", 0, 0, 8'h2E);

        // Aborted fourth word
        send(8'h11, 8, 1'b0);
        send(8'h22, 8, 1'b0);
        send(8'h33, 8, 1'b0);
        v0 = vcnt;
        send(8'h44, 5, 1'b0);
        chk("t3_short_err", int'(short_err), 1);
        chk("t3_no_valid", vcnt - v0, 0);
        send(8'h44, 8, 1'b0);
        chk("t3_row", int'(lrow), 0);
        chk("t3_col", int'(lcol), 3);
        rd("t3_rd_0_3", 0, 3, 8'h44);

        // 12 bits in one burst
        v0 = vcnt;
        send(8'h5A, 12, 1'b0);
        chk("t5_single_valid", vcnt - v0, 1);
        chk("t5_row", int'(lrow), 1);
        chk("t5_col", int'(lcol), 0);
        rd("t5_rd_1_0", 1, 0, 8'h5A);

        // Reset mid-word
        send(8'h66, 8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk); cs = 1'b1; sdi = 1'b1;
        end
        @(negedge sclk); reset = 1'b1; cs = 1'b0; sdi = 1'b0;
        @(negedge sclk);
        chk_all_zero("midreset");
        reset = 1'b0;
        @(negedge sclk);
        send(8'h77, 8, 1'b0);
        chk("t6_row", int'(lrow), 0);
        chk("t6_col", int'(lcol), 0);
        rd("t6_rd_0_0", 0, 0, 8'h77);

        // LSB-first instance
        send(8'hA5, 8, 1'b1);
        rd_row = 2'd0; rd_col = 2'd0; #1;
        chk("lsb_rd_0_0", int'(rd_data2), 8'hA5);
        chk("lsb_done", int'(done2), 0);
        chk("lsb_short_err", int'(short_err2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
